// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared constants for the data-side memory bridge.
//   IO page word offsets (mem_addr[3:2]) and STATUS register bit positions.
package mem_bridge_pkg;

   localparam logic [1:0] OFS_STATUS = 2'd0;
   localparam logic [1:0] OFS_KBD    = 2'd1;
   localparam logic [1:0] OFS_HEX    = 2'd2;
   localparam logic [1:0] OFS_CYCLE  = 2'd3;

   localparam int ST_NEMPTY = 0;
   localparam int ST_OVF    = 1;

endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo: keyboard scan-code FIFO with sticky overflow flag.
//   clk, rst    : clock, async active-high reset (empties FIFO, clears overflow)
//   push, din   : enqueue din; dropped when full unless a pop happens the same cycle
//   pop         : dequeue head (ignored when empty)
//   ovf_clr     : clear overflow; a same-cycle overflow event wins
//   head        : oldest entry
//   empty, full : occupancy flags
//   overflow    : sticky, set when a push is dropped
module kbd_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   input  logic       ovf_clr,
   output logic [7:0] head,
   output logic       empty,
   output logic       full,
   output logic       overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  store [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_pop;
   logic        do_push;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop && !empty;
   // A pop frees the slot at the same edge, so a full FIFO can still accept.
   assign do_push  = push && (!full || do_pop);
   assign head     = store[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
         if (push && !do_push) overflow <= 1'b1;
         else if (ovf_clr)     overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst) store[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: data-side bus stage between the single-cycle core and memory.
//   Decodes mem_addr to a word RAM or to the IO page at IO_BASE[31:16].
//   IO page: STATUS (W1C overflow), KBD_DATA (pop on load), HEX, CYCLE.
//   Optional: MEM_BRIDGE_CYCLE_COUNTER_EN adds the free-running cycle counter;
//   without it the CYCLE offset reads 0 and ignores writes.
// Ports:
//   clk, rst            : clock, async active-high reset
//   mem_addr, wren,
//   mem_rden, mem_wdata : core data bus (word access; addr[1:0] ignored)
//   mem_data            : combinational read data
//   kbd_valid, kbd_code : keyboard scan-code input
//   hex_out             : display register
//   kbd_irq             : FIFO not empty
module mem_bridge
   import mem_bridge_pkg::*;
#(
   parameter int          RAM_AW     = 10,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   input  logic        wren,
   input  logic        mem_rden,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_data,
   input  logic        kbd_valid,
   input  logic [7:0]  kbd_code,
   output logic [31:0] hex_out,
   output logic        kbd_irq
);

   logic [31:0]       ram [2**RAM_AW];
   logic [RAM_AW-1:0] ram_idx;
   logic              is_io;
   logic [1:0]        ofs;
   logic              kbd_pop;
   logic              ovf_clr;
   logic [7:0]        kbd_head;
   logic              kbd_empty;
   logic              kbd_ovf;
   logic              unused_fifo_full;
   logic              unused_addr;
   logic [31:0]       cycle_val;

   assign is_io       = (mem_addr[31:16] == IO_BASE[31:16]);
   assign ofs         = mem_addr[3:2];
   assign ram_idx     = mem_addr[RAM_AW+1:2];
   assign unused_addr = ^mem_addr[15:0];

   assign kbd_pop = mem_rden && is_io && (ofs == OFS_KBD);
   assign ovf_clr = wren && is_io && (ofs == OFS_STATUS) && mem_wdata[ST_OVF];
   assign kbd_irq = !kbd_empty;

   kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_kbd_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (kbd_valid),
      .din      (kbd_code),
      .pop      (kbd_pop),
      .ovf_clr  (ovf_clr),
      .head     (kbd_head),
      .empty    (kbd_empty),
      .full     (unused_fifo_full),
      .overflow (kbd_ovf)
   );

   // RAM is not reset; a write coinciding with reset is discarded.
   always_ff @(posedge clk) begin
      if (wren && !is_io && !rst) ram[ram_idx] <= mem_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                     hex_out <= '0;
      else if (wren && is_io && (ofs == OFS_HEX))  hex_out <= mem_wdata;
   end

`ifdef MEM_BRIDGE_CYCLE_COUNTER_EN
   logic [31:0] cycle_cnt;
   logic        cycle_wr;

   assign cycle_wr  = wren && is_io && (ofs == OFS_CYCLE);
   assign cycle_val = cycle_cnt;

   // A load replaces that cycle's increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           cycle_cnt <= '0;
      else if (cycle_wr) cycle_cnt <= mem_wdata;
      else               cycle_cnt <= cycle_cnt + 32'd1;
   end
`else
   assign cycle_val = '0;
`endif

   always_comb begin
      mem_data = ram[ram_idx];
      if (is_io) begin
         unique case (ofs)
            OFS_STATUS: mem_data = {30'b0, kbd_ovf, !kbd_empty};
            OFS_KBD:    mem_data = kbd_empty ? 32'd0 : {24'b0, kbd_head};
            OFS_HEX:    mem_data = hex_out;
            default:    mem_data = cycle_val;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bridge.sv
module tb_mem_bridge;

   localparam int DEPTH = 8;
   localparam logic [31:0] A_STATUS = 32'hFFFF_0000;
   localparam logic [31:0] A_KBD    = 32'hFFFF_0004;
   localparam logic [31:0] A_HEX    = 32'hFFFF_0008;
   localparam logic [31:0] A_CYCLE  = 32'hFFFF_000C;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] mem_addr = '0;
   logic        wren = 1'b0;
   logic        mem_rden = 1'b0;
   logic [31:0] mem_wdata = '0;
   logic        kbd_valid = 1'b0;
   logic [7:0]  kbd_code = '0;
   logic [31:0] mem_data;
   logic [31:0] hex_out;
   logic        kbd_irq;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

   mem_bridge dut (
      .clk       (clk),
      .rst       (rst),
      .mem_addr  (mem_addr),
      .wren      (wren),
      .mem_rden  (mem_rden),
      .mem_wdata (mem_wdata),
      .mem_data  (mem_data),
      .kbd_valid (kbd_valid),
      .kbd_code  (kbd_code),
      .hex_out   (hex_out),
      .kbd_irq   (kbd_irq)
   );

   // Behavioural model: sparse RAM array, scan-code queue, plain registers.
   logic [31:0]  m_ram   [1024];
   bit           m_ram_v [1024];
   logic [7:0]   q [$];
   bit           m_ovf;
   logic [31:0]  m_hex;
   logic [31:0]  m_cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit in_io(input logic [31:0] a);
      return a[31:16] == 16'hFFFF;
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a, output bit known);
      known = 1'b1;
      if (!in_io(a)) begin
         known = m_ram_v[a[11:2]];
         return m_ram[a[11:2]];
      end
      case (a[3:2])
         2'd0:    return {30'b0, m_ovf, q.size() != 0};
         2'd1:    return (q.size() != 0) ? {24'b0, q[0]} : 32'd0;
         2'd2:    return m_hex;
`ifdef MEM_BRIDGE_CYCLE_COUNTER_EN
         default: return m_cyc;
`else
         default: return 32'd0;
`endif
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin : model
      bit io;
      bit pop;
      int sz;
      if (rst) begin
         q.delete();
         m_ovf = 1'b0;
         m_hex = '0;
         m_cyc = '0;
      end else begin
         io  = in_io(mem_addr);
         sz  = q.size();
         pop = mem_rden && io && mem_addr[3:2] == 2'd1 && sz > 0;
         if (pop) void'(q.pop_front());
         if (kbd_valid) begin
            if (sz < DEPTH || pop) q.push_back(kbd_code);
            else                   m_ovf = 1'b1;
         end
         if (wren && io && mem_addr[3:2] == 2'd0 && mem_wdata[1]
             && !(kbd_valid && sz == DEPTH && !pop))
            m_ovf = 1'b0;
         if (wren && io && mem_addr[3:2] == 2'd2) m_hex = mem_wdata;
         if (wren && io && mem_addr[3:2] == 2'd3) m_cyc = mem_wdata;
         else                                     m_cyc = m_cyc + 32'd1;
         if (wren && !io) begin
            m_ram[mem_addr[11:2]]   = mem_wdata;
            m_ram_v[mem_addr[11:2]] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin : compare
      bit          known;
      logic [31:0] e;
      if (chk_en) begin
         e = exp_read(mem_addr, known);
         if (known) chk("mem_data", mem_data, e);
         chk("hex_out", hex_out, m_hex);
         chk("kbd_irq", {31'b0, kbd_irq}, {31'b0, q.size() != 0});
      end
   end

   task automatic drv(input logic [31:0] a, input bit w, input bit r, input logic [31:0] d,
                      input bit kv, input logic [7:0] kc);
      mem_addr  = a;
      wren      = w;
      mem_rden  = r;
      mem_wdata = d;
      kbd_valid = kv;
      kbd_code  = kc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
      drv(a, 0, 0, 0, 0, 0);
      #1;
      chk(name, mem_data, exp);
   endtask

   initial begin
      #1 rst = 1'b1;
      chk_en = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_hex", hex_out, 32'd0);
      chk("rst_irq", {31'b0, kbd_irq}, 32'd0);
      peek("rst_status", A_STATUS, 32'd0);
      tick();

      // RAM store / load and alias
      drv(32'h0000_0010, 1, 0, 32'hDEAD_BEEF, 0, 0);
      tick();
      peek("ram_load", 32'h0000_0010, 32'hDEAD_BEEF);
      peek("ram_alias", 32'h0000_1010, 32'hDEAD_BEEF);
      tick();

      // Push into empty FIFO with a same-cycle KBD load
      drv(A_KBD, 0, 1, 0, 1, 8'h1C);
      #1 chk("push_empty_read", mem_data, 32'd0);
      tick();
      drv(32'h0000_0020, 0, 0, 0, 1, 8'h32);
      tick();
      peek("status_nempty", A_STATUS, 32'd1);
      drv(A_KBD, 0, 1, 0, 0, 0);
      #1 chk("kbd_first", mem_data, 32'h1C);
      tick();
      chk("kbd_second", mem_data, 32'h32);
      tick();
      peek("status_empty", A_STATUS, 32'd0);
      drv(A_KBD, 0, 1, 0, 0, 0);
      #1 chk("kbd_empty_read", mem_data, 32'd0);
      tick();
      peek("status_still_empty", A_STATUS, 32'd0);

      // Overflow: nine pushes into depth eight
      for (int i = 0; i < 9; i++) begin
         drv(32'h0000_0040, 0, 0, 0, 1, 8'(8'h40 + i));
         tick();
      end
      peek("status_ovf", A_STATUS, 32'd3);
      drv(A_STATUS, 1, 0, 32'd2, 0, 0);
      tick();
      peek("status_w1c", A_STATUS, 32'd1);
      for (int i = 0; i < 8; i++) begin
         drv(A_KBD, 0, 1, 0, 0, 0);
         #1 chk("drain_ovf", mem_data, 32'(8'h40 + i));
         tick();
      end
      peek("status_drained", A_STATUS, 32'd0);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 8; i++) begin
         drv(32'h0000_0040, 0, 0, 0, 1, 8'(8'h60 + i));
         tick();
      end
      peek("status_full", A_STATUS, 32'd1);
      drv(A_KBD, 0, 1, 0, 1, 8'h77);
      #1 chk("full_pushpop_head", mem_data, 32'h60);
      tick();
      peek("status_no_ovf", A_STATUS, 32'd1);
      for (int i = 0; i < 8; i++) begin
         drv(A_KBD, 0, 1, 0, 0, 0);
         #1 chk("drain_full", mem_data, (i == 7) ? 32'h77 : 32'(8'h61 + i));
         tick();
      end
      peek("status_drained2", A_STATUS, 32'd0);

      // HEX write, then asynchronous reset mid-cycle
      drv(A_HEX, 1, 0, 32'h0000_1234, 1, 8'h5A);
      tick();
      chk("hex_write", hex_out, 32'h0000_1234);
      chk("irq_set", {31'b0, kbd_irq}, 32'd1);
      drv(A_HEX, 1, 0, 32'hAAAA_5555, 0, 0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_hex", hex_out, 32'd0);
      chk("async_rst_irq", {31'b0, kbd_irq}, 32'd0);
      tick();
      chk("rst_write_lost", hex_out, 32'd0);
      rst = 1'b0;
      tick();

      // CYCLE register
      drv(A_CYCLE, 1, 0, 32'hFFFF_FFFE, 0, 0);
      tick();
      drv(A_CYCLE, 0, 0, 0, 0, 0);
      tick();
`ifdef MEM_BRIDGE_CYCLE_COUNTER_EN
      chk("cycle_max", mem_data, 32'hFFFF_FFFF);
      tick();
      chk("cycle_wrap", mem_data, 32'h0000_0000);
`else
      chk("cycle_off", mem_data, 32'd0);
      tick();
      chk("cycle_off2", mem_data, 32'd0);
`endif

      // Randomized traffic checked by the compare process
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a;
         if ($urandom_range(0, 5) < 3) begin
            a = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 1) == 1) a[12] = 1'b1;
            a[1:0] = 2'($urandom_range(0, 3));
         end else begin
            a = {16'hFFFF, 12'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         end
         drv(a, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom,
             $urandom_range(0, 2) == 0, 8'($urandom));
         tick();
      end

      drv(32'h0, 0, 0, 0, 0, 0);
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
